wait_state_memory: RTL

//  Parametrised word-addressed memory on the shared processor data bus. It adds

---
 rtl/wait_state_memory.sv | 124 ++++++++++++
 1 files changed

// File: rtl/wait_state_memory.sv
// Word-addressed bus memory with programmable wait states, byte-lane writes and
// out-of-range flagging. Busy stalls the controller; Done pulses on completion.
module wait_state_memory #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   addr,
  inout  wire  [DATA_WIDTH-1:0]   data,
  input  logic                    MemWrt,
  input  logic                    enMem,
  input  logic [DATA_WIDTH/8-1:0] byteEn,
  output logic                    Busy,
  output logic                    Done,
  output logic                    addrErr
);

  // state | meaning
  // IDLE  | no access pending
  // BUSY  | wait states counting down; access happens when counter is zero
  // DONE  | one-cycle completion; a new request may be accepted here

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NB-1:0]           be_q;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    busy_d, done_d, err_d;
  logic                    accept, do_access;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   idx;

  logic [DATA_WIDTH-1:0]   mem [2**DEPTH_LOG2];

  assign in_range = (addr_q[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
  assign idx      = addr_q[DEPTH_LOG2-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (enMem) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - CW'(1);
          busy_d = 1'b1;
        end else begin
          do_access = 1'b1;
          state_d   = DONE;
          done_d    = 1'b1;
          err_d     = ~in_range;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      addrErr <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      Busy    <= busy_d;
      Done    <= done_d;
      addrErr <= err_d;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= data;
        be_q    <= byteEn;
        wr_q    <= MemWrt;
      end
      // out-of-range accesses of either kind leave rdata cleared
      if (do_access && (!wr_q || !in_range))
        rdata_q <= in_range ? mem[idx] : '0;
    end
  end

  // Array has no reset; an access aborted by reset never writes.
  always_ff @(posedge clock) begin
    if (!reset && do_access && wr_q && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign data = (enMem && !MemWrt) ? rdata_q : {DATA_WIDTH{1'bz}};

endmodule
